// File: rtl/check_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// check_scoreboard_pkg
// Shared definitions for the in-order check scoreboard:
//   - bit positions of the sticky error flags
//   - widths of the error vector and the match counter
//   - a saturating increment helper for the match counter
// -----------------------------------------------------------------------------
package check_scoreboard_pkg;

  localparam int ERR_MISMATCH  = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_OVERFLOW  = 2;
  localparam int ERR_TIMEOUT   = 3;
  localparam int ERR_W         = 4;

  localparam int MATCH_W = 16;

  typedef logic [ERR_W-1:0]   err_t;
  typedef logic [MATCH_W-1:0] match_t;

  // Counts up to all-ones and then sticks there.
  function automatic match_t sat_inc(input match_t v);
    return (v == '1) ? v : v + match_t'(1);
  endfunction

endpackage

// File: rtl/check_scoreboard_if.sv
// -----------------------------------------------------------------------------
// check_scoreboard_if
// Bundles the expected-word push, the actual-word compare and the status
// outputs of the scoreboard.
//   master : the testbench side (drives exp_* / act_*, reads status)
//   slave  : the scoreboard side
// Signals:
//   exp_valid/exp_data  push an expected word
//   act_valid/act_data  present an actual word for comparison
//   pass                ~|err
//   err                 sticky flags [0] mismatch [1] underflow [2] overflow [3] timeout
//   match_count         successful compares, saturating
//   pending             expected words not yet consumed
//   idle                pending==0 and no error
// -----------------------------------------------------------------------------
interface check_scoreboard_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  import check_scoreboard_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             exp_valid;
  logic [WIDTH-1:0] exp_data;
  logic             act_valid;
  logic [WIDTH-1:0] act_data;
  logic             pass;
  err_t             err;
  match_t           match_count;
  logic [CNT_W-1:0] pending;
  logic             idle;

  modport master (
    output exp_valid, exp_data, act_valid, act_data,
    input  pass, err, match_count, pending, idle
  );

  modport slave (
    input  exp_valid, exp_data, act_valid, act_data,
    output pass, err, match_count, pending, idle
  );

endinterface

// File: rtl/check_scoreboard_fifo.sv
// -----------------------------------------------------------------------------
// check_fifo
// Synchronous FIFO holding the expected words in arrival order.
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   push_i        write push_data_i this cycle (accepted when full only
//                 together with a pop)
//   push_data_i   word to write
//   pop_i         drop the head entry this cycle (ignored when empty)
//   head_o        oldest stored word
//   count_o       number of stored words, 0..DEPTH
//   full_o        count_o == DEPTH
//   empty_o       count_o == 0
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// -----------------------------------------------------------------------------
module check_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  always_comb begin
    wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d    = do_pop  ? rd_q + PTR_W'(1) : rd_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: the storage array has no reset; only pointers and count need a
  // known value, and entries are never read before being written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/check_scoreboard.sv
// -----------------------------------------------------------------------------
// check_scoreboard
// In-order scoreboard: expected words are queued, each actual word is
// compared against the oldest queued word. Error flags are sticky until rst.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; flushes queue, flags and counters
//   sb    check_scoreboard_if.slave (exp_*, act_* in; pass, err,
//         match_count, pending, idle out)
// Parameters:
//   WIDTH    data word width
//   DEPTH    expected-queue entries (power of two, >= 2)
//   TIMEOUT  stalled cycles (words pending, no act_valid) before err[3]
// -----------------------------------------------------------------------------
module check_scoreboard
  import check_scoreboard_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input logic                clk,
  input logic                rst,
  check_scoreboard_if.slave  sb
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TCNT_W-1:0] TLIMIT = TCNT_W'(TIMEOUT - 1);

  logic [WIDTH-1:0]  head;
  logic [CNT_W-1:0]  count;
  logic              full, empty;

  logic              do_pop, do_push;
  logic              mismatch, underflow, overflow, timeout_hit;

  err_t              err_q, err_d;
  match_t            match_q, match_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  check_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (do_push),
    .push_data_i (sb.exp_data),
    .pop_i       (do_pop),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full),
    .empty_o     (empty)
  );

  // NOTE: every signal gets its default before any branch, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    do_pop      = sb.act_valid && !empty;
    // Empty queue: the compare fails even if a push lands this same cycle.
    underflow   = sb.act_valid && empty;
    // NOTE: !== makes an X/Z on either side count as a mismatch instead of
    // evaluating to unknown and slipping through.
    mismatch    = do_pop && (sb.act_data !== head);
    do_push     = sb.exp_valid && (!full || do_pop);
    overflow    = sb.exp_valid && full && !do_pop;

    timeout_hit = 1'b0;
    tcnt_d      = tcnt_q + TCNT_W'(1);
    if (sb.act_valid || empty) begin
      tcnt_d = '0;
    end else if (tcnt_q == TLIMIT) begin
      // Counter parks at the limit; the flag is sticky so holding is enough.
      tcnt_d      = tcnt_q;
      timeout_hit = 1'b1;
    end

    err_d = err_q;
    if (mismatch)    err_d[ERR_MISMATCH]  = 1'b1;
    if (underflow)   err_d[ERR_UNDERFLOW] = 1'b1;
    if (overflow)    err_d[ERR_OVERFLOW]  = 1'b1;
    if (timeout_hit) err_d[ERR_TIMEOUT]   = 1'b1;

    match_d = (do_pop && !mismatch) ? sat_inc(match_q) : match_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= '0;
      match_q <= '0;
      tcnt_q  <= '0;
    end else begin
      err_q   <= err_d;
      match_q <= match_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign sb.err         = err_q;
  assign sb.pass        = ~|err_q;
  assign sb.idle        = empty && ~|err_q;
  assign sb.match_count = match_q;
  assign sb.pending     = count;

endmodule
